// File: rtl/crc_input_buffer.sv
// Write buffer between the AHB host interface and the byte-wide CRC engine.
// Reverses CRC_DR writes on entry, queues them, and serialises each entry LSB byte first.
module crc_input_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] bus_wr,
   input  logic [1:0]  bus_size,
   input  logic        buffer_write_en,
   input  logic [1:0]  rev_in_type,
   input  logic        reset_chain,
   input  logic        byte_ready,
   input  logic        crc_busy,
   output logic        buffer_full,
   output logic        read_wait,
   output logic        reset_pending,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        byte_last,
   output logic        crc_init_load
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH_WAIT, FLUSH} state_t;

   // Reversal unit is the smaller of the requested unit and the write size,
   // so bits never cross out of the lanes that were actually written.
   function automatic logic [31:0] reverse_in(input logic [31:0] d,
                                              input logic [1:0]  size,
                                              input logic [1:0]  rev);
      logic [1:0]  size_unit;
      logic [1:0]  unit;
      logic [31:0] r;
      size_unit = size[1] ? 2'd3 : (size[0] ? 2'd2 : 2'd1);
      unit      = (rev < size_unit) ? rev : size_unit;
      r         = d;
      case (unit)
         2'd1: for (int i = 0; i < 32; i++) r[i] = d[(i & ~7)  + 7  - (i & 7)];
         2'd2: for (int i = 0; i < 32; i++) r[i] = d[(i & ~15) + 15 - (i & 15)];
         2'd3: for (int i = 0; i < 32; i++) r[i] = d[31 - i];
         default: r = d;
      endcase
      return r;
   endfunction

   state_t          state, state_nxt;
   logic [33:0]     mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic [31:0]     sh_data;
   logic [1:0]      sh_size;
   logic [1:0]      byte_idx;
   logic [1:0]      last_idx;
   logic            is_last, accept, push, pop, advance, flush_enter, fifo_empty;

   assign fifo_empty  = (count == '0);
   assign last_idx    = sh_size[1] ? 2'd3 : {1'b0, sh_size[0]};
   assign is_last     = (byte_idx == last_idx);
   assign accept      = byte_valid && byte_ready;
   assign buffer_full = (count == CNT_FULL) || reset_pending;
   assign push        = buffer_write_en && !buffer_full && !reset_chain;
   assign pop         = !fifo_empty && !reset_chain &&
                        ((state == IDLE) || (state == SHIFT && accept && is_last));
   assign advance     = (state == SHIFT) && accept && !is_last;
   assign flush_enter = (state_nxt == FLUSH);

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      // NOTE: sequential state is always assigned with <=, so every flop samples
      // pre-edge values and simulation matches the synthesised netlist.
      if (!HRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first; any path that skips it would infer a latch.
      state_nxt = state;
      case (state)
         IDLE: begin
            if (reset_chain)      state_nxt = FLUSH;
            else if (!fifo_empty) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (reset_chain)           state_nxt = byte_ready ? FLUSH : FLUSH_WAIT;
            else if (accept && is_last) state_nxt = fifo_empty ? IDLE : SHIFT;
         end
         FLUSH_WAIT: if (byte_ready) state_nxt = FLUSH;
         FLUSH:      state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      byte_valid    = (state == SHIFT) || (state == FLUSH_WAIT);
      reset_pending = (state == FLUSH_WAIT) || (state == FLUSH);
      crc_init_load = (state == FLUSH);
      byte_last     = byte_valid && is_last;
      byte_out      = sh_data[{byte_idx, 3'b000} +: 8];
      read_wait     = !fifo_empty || byte_valid || crc_busy;
   end

   // NOTE: the entry storage has no reset; validity is tracked by count and the
   // pointers alone, which keeps the array a plain RAM.
   always_ff @(posedge HCLK) begin
      if (push) mem[wr_ptr] <= {reverse_in(bus_wr, bus_size, rev_in_type), bus_size};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         sh_data  <= '0;
         sh_size  <= '0;
         byte_idx <= '0;
      end else if (flush_enter) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         sh_data  <= '0;
         sh_size  <= '0;
         byte_idx <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr              <= rd_ptr + PTR_ONE;
            {sh_data, sh_size}  <= mem[rd_ptr];
            byte_idx            <= '0;
         end else if (advance) begin
            byte_idx <= byte_idx + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_input_buffer.sv
// Self-checking bench for crc_input_buffer: directed vector table, multi-cycle corner
// sequences, and a randomized byte stream compared against a queue-based reference.
module tb_crc_input_buffer;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] bus_wr;
   logic [1:0]  bus_size;
   logic        buffer_write_en;
   logic [1:0]  rev_in_type;
   logic        reset_chain;
   logic        byte_ready;
   logic        crc_busy;
   logic        buffer_full, read_wait, reset_pending;
   logic [7:0]  byte_out;
   logic        byte_valid, byte_last, crc_init_load;

   int n_vec = 0;
   int n_err = 0;

   crc_input_buffer #(.DEPTH(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus_wr(bus_wr), .bus_size(bus_size),
      .buffer_write_en(buffer_write_en), .rev_in_type(rev_in_type),
      .reset_chain(reset_chain), .byte_ready(byte_ready), .crc_busy(crc_busy),
      .buffer_full(buffer_full), .read_wait(read_wait), .reset_pending(reset_pending),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
      .crc_init_load(crc_init_load)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [1:0]  size;
      logic [1:0]  rev;
      logic [31:0] data;
      logic [31:0] exp;   // expected bytes, byte i at exp[8i+:8]
      int          n;
   } vec_t;

   typedef struct {
      logic [7:0] b;
      logic       last;
   } exp_byte_t;

   vec_t      vecs[9];
   exp_byte_t q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic write_word(input logic [31:0] d, input logic [1:0] s, input logic [1:0] r);
      bus_wr = d; bus_size = s; rev_in_type = r; buffer_write_en = 1'b1;
      tick();
      buffer_write_en = 1'b0;
   endtask

   // Expects byte_ready=1 and the first byte of the entry already presented.
   task automatic expect_stream(input string name, input logic [31:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check({name, "_valid"}, byte_valid, 1'b1);
         check({name, "_byte"}, byte_out, exp[8*i +: 8]);
         check({name, "_last"}, byte_last, (i == n - 1));
         check({name, "_rwait"}, read_wait, 1'b1);
         tick();
      end
   endtask

   // Reference: bits reversed in chunks of min(rev unit, size) bytes, computed arithmetically.
   function automatic int ref_n(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_rev(input logic [31:0] d, input logic [1:0] s,
                                           input logic [1:0] r);
      int          g, w;
      logic [31:0] o;
      g = (r == 2'd0) ? 0 : (1 << (r - 1));
      if (ref_n(s) < g) g = ref_n(s);
      if (g == 0) return d;
      w = 8 * g;
      o = d;
      for (int base = 0; base < 32; base += w)
         for (int b = 0; b < w; b++) o[base + b] = d[base + w - 1 - b];
      return o;
   endfunction

   initial begin
      vecs[0] = '{2'd2, 2'd0, 32'h44332211, 32'h44332211, 4};
      vecs[1] = '{2'd0, 2'd1, 32'h00000001, 32'h00000080, 1};
      vecs[2] = '{2'd1, 2'd2, 32'h00000001, 32'h00008000, 2};
      vecs[3] = '{2'd2, 2'd3, 32'h00000001, 32'h80000000, 4};
      vecs[4] = '{2'd0, 2'd3, 32'h00000001, 32'h00000080, 1};
      vecs[5] = '{2'd1, 2'd1, 32'h00000001, 32'h00000080, 2};
      vecs[6] = '{2'd2, 2'd2, 32'h00000001, 32'h00008000, 4};
      vecs[7] = '{2'd3, 2'd1, 32'h12345678, 32'h482C6A1E, 4};
      vecs[8] = '{2'd1, 2'd3, 32'hFFFF0001, 32'h00008000, 2};

      HRESETn = 1'b0; bus_wr = '0; bus_size = '0; buffer_write_en = 1'b0;
      rev_in_type = '0; reset_chain = 1'b0; byte_ready = 1'b0; crc_busy = 1'b0;

      // Reset state
      #12;
      check("rst_valid", byte_valid, 1'b0);
      check("rst_full", buffer_full, 1'b0);
      check("rst_pending", reset_pending, 1'b0);
      check("rst_init", crc_init_load, 1'b0);
      check("rst_byte", {byte_last, byte_out}, 9'h0);
      check("rst_rwait0", read_wait, 1'b0);
      crc_busy = 1'b1; #1;
      check("rst_rwait1", read_wait, 1'b1);
      crc_busy = 1'b0;
      @(negedge HCLK); HRESETn = 1'b1;
      tick();

      // Vector table: latency, byte order, byte_last, reversal granularity
      byte_ready = 1'b1;
      foreach (vecs[k]) begin
         write_word(vecs[k].data, vecs[k].size, vecs[k].rev);
         check("tbl_latency", byte_valid, 1'b0);
         check("tbl_rwait_pre", read_wait, 1'b1);
         tick();
         expect_stream($sformatf("tbl%0d", k), vecs[k].exp, vecs[k].n);
         check("tbl_done_valid", byte_valid, 1'b0);
         check("tbl_done_rwait", read_wait, 1'b0);
      end

      // Full buffer, dropped write, no-bubble handover
      byte_ready = 1'b0;
      write_word(32'hA3A2A1A0, 2'd2, 2'd0);
      write_word(32'hB3B2B1B0, 2'd2, 2'd0);
      write_word(32'hC3C2C1C0, 2'd2, 2'd0);
      check("full_after3", buffer_full, 1'b1);
      write_word(32'hD3D2D1D0, 2'd2, 2'd0);
      check("full_after_drop", buffer_full, 1'b1);
      check("full_held_byte", byte_out, 8'hA0);
      byte_ready = 1'b1;
      tick(); tick(); tick(); tick();
      check("full_released", buffer_full, 1'b0);
      expect_stream("full_B", 32'hB3B2B1B0, 4);
      expect_stream("full_C", 32'hC3C2C1C0, 4);
      check("full_no_D", byte_valid, 1'b0);

      // Flush while stalled with two queued entries; concurrent write dropped
      byte_ready = 1'b0;
      write_word(32'hA3A2A1A0, 2'd2, 2'd0);
      write_word(32'hB3B2B1B0, 2'd2, 2'd0);
      write_word(32'hC3C2C1C0, 2'd2, 2'd0);
      reset_chain = 1'b1; buffer_write_en = 1'b1; bus_wr = 32'hD3D2D1D0;
      tick();
      buffer_write_en = 1'b0;
      check("fl_pending", reset_pending, 1'b1);
      check("fl_full", buffer_full, 1'b1);
      check("fl_valid", byte_valid, 1'b1);
      check("fl_byte", byte_out, 8'hA0);
      check("fl_no_init", crc_init_load, 1'b0);
      tick();
      reset_chain = 1'b0;
      check("fl_hold_valid", byte_valid, 1'b1);
      check("fl_hold_pending", reset_pending, 1'b1);
      byte_ready = 1'b1;
      tick();
      check("fl_init_pulse", crc_init_load, 1'b1);
      check("fl_valid_drop", byte_valid, 1'b0);
      check("fl_empty", read_wait, 1'b0);
      check("fl_pending2", reset_pending, 1'b1);
      tick();
      check("fl_init_end", crc_init_load, 1'b0);
      check("fl_pending_end", reset_pending, 1'b0);
      check("fl_full_end", buffer_full, 1'b0);
      check("fl_idle_valid", byte_valid, 1'b0);
      write_word(32'h87654321, 2'd2, 2'd0);
      tick();
      expect_stream("fl_after", 32'h87654321, 4);
      check("fl_after_done", byte_valid, 1'b0);

      // Flush requested from idle
      reset_chain = 1'b1;
      tick();
      reset_chain = 1'b0;
      check("idle_fl_pending", reset_pending, 1'b1);
      check("idle_fl_init", crc_init_load, 1'b1);
      tick();
      check("idle_fl_init_end", crc_init_load, 1'b0);
      check("idle_fl_pending_end", reset_pending, 1'b0);

      // Asynchronous reset mid-entry
      write_word(32'h44332211, 2'd2, 2'd0);
      tick();
      tick();
      byte_ready = 1'b0;
      check("ar_mid_byte", byte_out, 8'h22);
      #2 HRESETn = 1'b0;
      #1;
      check("ar_valid", byte_valid, 1'b0);
      check("ar_byte", {byte_last, byte_out}, 9'h0);
      check("ar_flags", {buffer_full, reset_pending, crc_init_load, read_wait}, 4'h0);
      @(negedge HCLK); HRESETn = 1'b1;
      tick();
      byte_ready = 1'b1;
      write_word(32'h0A0B0C0D, 2'd2, 2'd0);
      tick();
      expect_stream("ar_after", 32'h0A0B0C0D, 4);
      check("ar_after_done", byte_valid, 1'b0);

      // Randomized mixed-size writes against the queue reference
      begin
         int         writes_left = 16;
         int         cyc = 0;
         logic       stalled = 1'b0;
         logic [7:0] held_b = '0;
         logic       held_l = 1'b0;
         while ((writes_left > 0 || q.size() > 0) && cyc < 2000) begin
            if (writes_left > 0 && $urandom_range(0, 1) == 1 && !buffer_full) begin
               logic [31:0] d, e;
               logic [1:0]  s, r;
               d = $urandom; s = 2'($urandom_range(0, 3)); r = 2'($urandom_range(0, 3));
               e = ref_rev(d, s, r);
               for (int i = 0; i < ref_n(s); i++) q.push_back('{e[8*i +: 8], i == ref_n(s) - 1});
               bus_wr = d; bus_size = s; rev_in_type = r; buffer_write_en = 1'b1;
               writes_left--;
            end else begin
               buffer_write_en = 1'b0;
            end
            byte_ready = ($urandom_range(0, 3) != 0);
            @(negedge HCLK);
            if (stalled) begin
               check("rnd_stall_valid", byte_valid, 1'b1);
               check("rnd_stall_byte", {byte_last, byte_out}, {held_l, held_b});
            end
            if (byte_valid && byte_ready) begin
               check("rnd_extra_byte", q.size() > 0, 1'b1);
               if (q.size() > 0) begin
                  exp_byte_t x;
                  x = q.pop_front();
                  check("rnd_byte", {byte_last, byte_out}, {x.last, x.b});
               end
            end
            stalled = byte_valid && !byte_ready;
            held_b  = byte_out;
            held_l  = byte_last;
            tick();
            cyc++;
         end
         buffer_write_en = 1'b0;
         check("rnd_timeout", cyc < 2000, 1'b1);
         check("rnd_left", q.size(), 0);
         check("rnd_idle", byte_valid, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
